// File: rtl/udt_ctrl_classifier.sv
`default_nettype none
// ============================================================================
// Module   : udt_ctrl_classifier
// Brief    : Decodes the UDT header on beat 0 and steers packets to the data,
//            control, handshake (store-and-forward) or shutdown paths.
//            Optional counters enabled by macro UDT_CLS_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module udt_ctrl_classifier #(
  parameter int HS_BEATS = 8
) (
  input  logic        core_clk,
  input  logic        core_rst_n,
  input  logic [63:0] s_tdata,
  input  logic [7:0]  s_tkeep,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        s_tlast,
  output logic [63:0] handshake_tdata,
  output logic [7:0]  handshake_tkeep,
  output logic        handshake_tvalid,
  input  logic        handshake_tready,
  output logic        handshake_tlast,
  output logic        close_tvalid,
  input  logic        close_tready,
  output logic [63:0] ctrl_tdata,
  output logic [7:0]  ctrl_tkeep,
  output logic        ctrl_tvalid,
  input  logic        ctrl_tready,
  output logic        ctrl_tlast,
  output logic [63:0] data_tdata,
  output logic [7:0]  data_tkeep,
  output logic        data_tvalid,
  input  logic        data_tready,
  output logic        data_tlast,
  output logic [31:0] rx_pkt_cnt,
  output logic [15:0] hs_drop_cnt
);

  localparam int C_CNT_W = $clog2(HS_BEATS + 1);
  localparam int C_PTR_W = (HS_BEATS > 1) ? $clog2(HS_BEATS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CUT_DATA  = 3'd1,
    ST_CUT_CTRL  = 3'd2,
    ST_HS_FILL   = 3'd3,
    ST_SHUT_SINK = 3'd4,
    ST_DROP      = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    RT_DATA = 2'd0,
    RT_HS   = 2'd1,
    RT_SHUT = 2'd2,
    RT_CTRL = 2'd3
  } route_t;

  state_t                 r_state;
  state_t                 w_next;
  route_t                 w_route;
  logic                   w_s_ready;
  logic                   w_s_fire;
  logic                   w_data_sel;
  logic                   w_ctrl_sel;
  logic                   w_hs_wr;
  logic                   w_hs_beat;
  logic                   w_shut_beat;

  logic [71:0]            r_hs_mem [HS_BEATS];
  logic [C_CNT_W-1:0]     r_fill_cnt;
  logic                   r_keep_ok;
  logic                   r_hs_busy;
  logic [C_PTR_W-1:0]     r_rd_ptr;
  logic                   r_close;

  logic [C_CNT_W-1:0]     w_fill_idx;
  logic                   w_keep_ok;
  logic                   w_hs_good;
  logic                   w_hs_end;
  logic                   w_hs_commit;
  logic                   w_shut_end;
  logic                   w_hs_out_fire;
  logic                   w_hs_out_last;

  always_comb begin
    w_route = RT_CTRL;
    if (!s_tdata[63])
      w_route = RT_DATA;
    else if (s_tdata[62:48] == 15'd0)
      w_route = RT_HS;
    else if (s_tdata[62:48] == 15'd5)
      w_route = RT_SHUT;
  end

  always_ff @(posedge core_clk) begin
    if (!core_rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_s_ready   = 1'b0;
    w_data_sel  = 1'b0;
    w_ctrl_sel  = 1'b0;
    w_hs_wr     = 1'b0;
    w_hs_beat   = 1'b0;
    w_shut_beat = 1'b0;
    case (r_state)
      ST_IDLE: begin
        case (w_route)
          RT_DATA: begin
            w_data_sel = 1'b1;
            w_s_ready  = data_tready;
          end
          RT_CTRL: begin
            w_ctrl_sel = 1'b1;
            w_s_ready  = ctrl_tready;
          end
          RT_HS: begin
            w_s_ready = 1'b1;
            w_hs_beat = 1'b1;
            w_hs_wr   = !r_hs_busy;
          end
          default: begin
            w_s_ready   = 1'b1;
            w_shut_beat = 1'b1;
          end
        endcase
        // Single-beat packets finish in IDLE; longer ones move to their path.
        if (s_tvalid && w_s_ready && !s_tlast) begin
          case (w_route)
            RT_DATA: w_next = ST_CUT_DATA;
            RT_CTRL: w_next = ST_CUT_CTRL;
            RT_HS:   w_next = r_hs_busy ? ST_DROP : ST_HS_FILL;
            default: w_next = ST_SHUT_SINK;
          endcase
        end
      end
      ST_CUT_DATA: begin
        w_data_sel = 1'b1;
        w_s_ready  = data_tready;
      end
      ST_CUT_CTRL: begin
        w_ctrl_sel = 1'b1;
        w_s_ready  = ctrl_tready;
      end
      ST_HS_FILL: begin
        w_s_ready = 1'b1;
        w_hs_beat = 1'b1;
        w_hs_wr   = 1'b1;
      end
      ST_SHUT_SINK: begin
        w_s_ready   = 1'b1;
        w_shut_beat = 1'b1;
      end
      ST_DROP: begin
        w_s_ready = 1'b1;
        w_hs_beat = 1'b1;
      end
      default: w_next = ST_IDLE;
    endcase
    if (r_state != ST_IDLE && s_tvalid && w_s_ready && s_tlast)
      w_next = ST_IDLE;
  end

  assign s_tready    = core_rst_n & w_s_ready;
  assign w_s_fire    = s_tvalid & s_tready;

  assign data_tdata  = s_tdata;
  assign data_tkeep  = s_tkeep;
  assign data_tlast  = s_tlast;
  assign data_tvalid = core_rst_n & s_tvalid & w_data_sel;
  assign ctrl_tdata  = s_tdata;
  assign ctrl_tkeep  = s_tkeep;
  assign ctrl_tlast  = s_tlast;
  assign ctrl_tvalid = core_rst_n & s_tvalid & w_ctrl_sel;

  // Fill index saturates at HS_BEATS so oversize packets can never validate.
  assign w_fill_idx  = (r_state == ST_IDLE) ? '0 : r_fill_cnt;
  assign w_keep_ok   = ((r_state == ST_IDLE) ? 1'b1 : r_keep_ok) && (s_tkeep == 8'hFF);
  assign w_hs_good   = (w_fill_idx == C_CNT_W'(HS_BEATS - 1)) && w_keep_ok;
  assign w_hs_end    = w_s_fire && s_tlast && w_hs_beat;
  assign w_hs_commit = w_hs_end && w_hs_wr && w_hs_good;
  assign w_shut_end  = w_s_fire && s_tlast && w_shut_beat;

  always_ff @(posedge core_clk) begin
    if (w_s_fire && w_hs_wr && (w_fill_idx < C_CNT_W'(HS_BEATS)))
      r_hs_mem[w_fill_idx[C_PTR_W-1:0]] <= {s_tkeep, s_tdata};
  end

  always_ff @(posedge core_clk) begin
    if (!core_rst_n) begin
      r_fill_cnt <= '0;
      r_keep_ok  <= 1'b1;
    end else if (w_s_fire && w_hs_wr) begin
      r_fill_cnt <= (w_fill_idx == C_CNT_W'(HS_BEATS)) ? w_fill_idx : w_fill_idx + 1'b1;
      r_keep_ok  <= w_keep_ok;
    end
  end

  assign w_hs_out_last = (r_rd_ptr == C_PTR_W'(HS_BEATS - 1));
  assign w_hs_out_fire = r_hs_busy && handshake_tready;

  always_ff @(posedge core_clk) begin
    if (!core_rst_n) begin
      r_hs_busy <= 1'b0;
      r_rd_ptr  <= '0;
    end else if (w_hs_commit) begin
      r_hs_busy <= 1'b1;
      r_rd_ptr  <= '0;
    end else if (w_hs_out_fire) begin
      if (w_hs_out_last) begin
        r_hs_busy <= 1'b0;
        r_rd_ptr  <= '0;
      end else begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
      end
    end
  end

  assign handshake_tvalid = r_hs_busy;
  assign handshake_tdata  = r_hs_mem[r_rd_ptr][63:0];
  assign handshake_tkeep  = r_hs_mem[r_rd_ptr][71:64];
  assign handshake_tlast  = w_hs_out_last;

  // A shutdown arriving while one is pending simply keeps the flag set.
  always_ff @(posedge core_clk) begin
    if (!core_rst_n)
      r_close <= 1'b0;
    else if (w_shut_end)
      r_close <= 1'b1;
    else if (close_tready)
      r_close <= 1'b0;
  end

  assign close_tvalid = r_close;

`ifdef UDT_CLS_STATS_EN
  logic [31:0] r_rx_cnt;
  logic [15:0] r_drop_cnt;
  logic        w_hs_drop;

  assign w_hs_drop = w_hs_end && !w_hs_commit;

  always_ff @(posedge core_clk) begin
    if (!core_rst_n) begin
      r_rx_cnt   <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_s_fire && s_tlast)
        r_rx_cnt <= r_rx_cnt + 32'd1;
      if (w_hs_drop && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign rx_pkt_cnt  = r_rx_cnt;
  assign hs_drop_cnt = r_drop_cnt;
`else
  assign rx_pkt_cnt  = '0;
  assign hs_drop_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_udt_ctrl_classifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_udt_ctrl_classifier
// Brief    : Scoreboard bench for udt_ctrl_classifier with directed packets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_udt_ctrl_classifier;

`ifdef UDT_CLS_STATS_EN
  localparam bit C_STATS = 1'b1;
`else
  localparam bit C_STATS = 1'b0;
`endif

  localparam logic [63:0] C_HDR_DATA = 64'h0000_0001_0000_0000;
  localparam logic [63:0] C_HDR_HS   = 64'h8000_0000_0000_0000;
  localparam logic [63:0] C_HDR_SHUT = 64'h8005_0000_0000_0000;
  localparam logic [63:0] C_HDR_ACK  = 64'h8002_0000_0000_0000;
  localparam int C_NONE = 0, C_DATA = 1, C_CTRL = 2, C_HS = 3;

  logic        core_clk = 1'b0;
  logic        core_rst_n = 1'b0;
  logic [63:0] s_tdata = '0;
  logic [7:0]  s_tkeep = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [63:0] handshake_tdata;
  logic [7:0]  handshake_tkeep;
  logic        handshake_tvalid;
  logic        handshake_tready = 1'b0;
  logic        handshake_tlast;
  logic        close_tvalid;
  logic        close_tready = 1'b0;
  logic [63:0] ctrl_tdata;
  logic [7:0]  ctrl_tkeep;
  logic        ctrl_tvalid;
  logic        ctrl_tready = 1'b0;
  logic        ctrl_tlast;
  logic [63:0] data_tdata;
  logic [7:0]  data_tkeep;
  logic        data_tvalid;
  logic        data_tready = 1'b0;
  logic        data_tlast;
  logic [31:0] rx_pkt_cnt;
  logic [15:0] hs_drop_cnt;

  int checks = 0;
  int errors = 0;
  int exp_rx = 0;
  int exp_drop = 0;
  int close_pend = 0;
  bit tog_en = 1'b0;
  logic [72:0] q_data[$];
  logic [72:0] q_ctrl[$];
  logic [72:0] q_hs[$];

  udt_ctrl_classifier #(.HS_BEATS(8)) dut (
    .core_clk(core_clk), .core_rst_n(core_rst_n),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid),
    .s_tready(s_tready), .s_tlast(s_tlast),
    .handshake_tdata(handshake_tdata), .handshake_tkeep(handshake_tkeep),
    .handshake_tvalid(handshake_tvalid), .handshake_tready(handshake_tready),
    .handshake_tlast(handshake_tlast),
    .close_tvalid(close_tvalid), .close_tready(close_tready),
    .ctrl_tdata(ctrl_tdata), .ctrl_tkeep(ctrl_tkeep), .ctrl_tvalid(ctrl_tvalid),
    .ctrl_tready(ctrl_tready), .ctrl_tlast(ctrl_tlast),
    .data_tdata(data_tdata), .data_tkeep(data_tkeep), .data_tvalid(data_tvalid),
    .data_tready(data_tready), .data_tlast(data_tlast),
    .rx_pkt_cnt(rx_pkt_cnt), .hs_drop_cnt(hs_drop_cnt)
  );

  always #5 core_clk = ~core_clk;

  always @(posedge core_clk) if (tog_en) #1 data_tready = ~data_tready;

  // Monitor: pop the expected beat on every output handshake.
  always @(negedge core_clk) begin
    logic [72:0] e;
    if (core_rst_n) begin
      if (data_tvalid && data_tready) begin
        checks++;
        if (q_data.size() == 0) begin
          errors++; $display("FAIL data_unexpected got=%h", {data_tlast, data_tkeep, data_tdata});
        end else begin
          e = q_data.pop_front();
          if (e !== {data_tlast, data_tkeep, data_tdata}) begin
            errors++; $display("FAIL data_beat got=%h exp=%h", {data_tlast, data_tkeep, data_tdata}, e);
          end
        end
      end
      if (ctrl_tvalid && ctrl_tready) begin
        checks++;
        if (q_ctrl.size() == 0) begin
          errors++; $display("FAIL ctrl_unexpected got=%h", {ctrl_tlast, ctrl_tkeep, ctrl_tdata});
        end else begin
          e = q_ctrl.pop_front();
          if (e !== {ctrl_tlast, ctrl_tkeep, ctrl_tdata}) begin
            errors++; $display("FAIL ctrl_beat got=%h exp=%h", {ctrl_tlast, ctrl_tkeep, ctrl_tdata}, e);
          end
        end
      end
      if (handshake_tvalid && handshake_tready) begin
        checks++;
        if (q_hs.size() == 0) begin
          errors++; $display("FAIL hs_unexpected got=%h", {handshake_tlast, handshake_tkeep, handshake_tdata});
        end else begin
          e = q_hs.pop_front();
          if (e !== {handshake_tlast, handshake_tkeep, handshake_tdata}) begin
            errors++; $display("FAIL hs_beat got=%h exp=%h", {handshake_tlast, handshake_tkeep, handshake_tdata}, e);
          end
        end
      end
      if (close_tvalid && close_tready) begin
        checks++;
        if (close_pend == 0) begin
          errors++; $display("FAIL close_unexpected got=1 exp=0");
        end else begin
          close_pend--;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++; $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic l, output int waits);
    bit ok;
    bit done;
    s_tdata = d; s_tkeep = 8'hFF; s_tlast = l; s_tvalid = 1'b1;
    waits = 0; done = 1'b0;
    while (!done) begin
      @(negedge core_clk); ok = s_tready;
      @(posedge core_clk); #1;
      if (ok) done = 1'b1;
      else begin
        waits++;
        if (waits > 200) begin
          checks++; errors++; $display("FAIL s_accept_timeout waited=%0d", waits);
          done = 1'b1;
        end
      end
    end
    s_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input logic [63:0] hdr, input int n, input int dest, output int first_waits);
    int w;
    logic [63:0] d;
    for (int i = 0; i < n; i++) begin
      d = hdr + 64'(i) * 64'h0000_0000_0000_0101;
      case (dest)
        C_DATA: q_data.push_back({(i == n - 1), 8'hFF, d});
        C_CTRL: q_ctrl.push_back({(i == n - 1), 8'hFF, d});
        C_HS:   q_hs.push_back({(i == n - 1), 8'hFF, d});
        default: ;
      endcase
    end
    for (int i = 0; i < n; i++) begin
      d = hdr + 64'(i) * 64'h0000_0000_0000_0101;
      send_beat(d, (i == n - 1), w);
      if (i == 0) first_waits = w;
    end
    exp_rx++;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((q_data.size() + q_ctrl.size() + q_hs.size() + close_pend) != 0 && n < budget) begin
      @(posedge core_clk); n++;
    end
    #1;
    check(name, 64'(q_data.size() + q_ctrl.size() + q_hs.size() + close_pend), 64'd0);
  endtask

  task automatic check_stats(input string name);
    @(negedge core_clk);
    check({name, "_rx"}, 64'(rx_pkt_cnt), C_STATS ? 64'(exp_rx) : 64'd0);
    check({name, "_drop"}, 64'(hs_drop_cnt), C_STATS ? 64'(exp_drop) : 64'd0);
    @(posedge core_clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [63:0] d;
    repeat (3) @(posedge core_clk);
    @(negedge core_clk);
    check("reset_outputs", {59'd0, data_tvalid, ctrl_tvalid, handshake_tvalid, close_tvalid, s_tready}, 64'd0);
    check("reset_counters", {rx_pkt_cnt, hs_drop_cnt, 16'd0}, 64'd0);
    @(posedge core_clk); #1;
    core_rst_n = 1'b1; handshake_tready = 1'b1;

    // Data packet with toggling backpressure
    tog_en = 1'b1;
    send_pkt(C_HDR_DATA, 4, C_DATA, w);
    tog_en = 1'b0;
    @(posedge core_clk); #2; data_tready = 1'b1;
    wait_idle("data_drain", 20);

    // Valid handshake: output appears the cycle after the last input beat
    for (int i = 0; i < 8; i++)
      q_hs.push_back({(i == 7), 8'hFF, C_HDR_HS + 64'(i) * 64'h101});
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("hs_early", 64'(handshake_tvalid), 64'd0);
      send_beat(C_HDR_HS + 64'(i) * 64'h101, (i == 7), w);
    end
    exp_rx++;
    check("hs_latency", 64'(handshake_tvalid), 64'd1);
    wait_idle("hs_drain", 30);
    check_stats("after_hs");

    // Short handshake is dropped
    send_pkt(C_HDR_HS, 6, C_NONE, w);
    exp_drop++;
    repeat (12) @(posedge core_clk); #1;
    check("short_hs_none", 64'(handshake_tvalid), 64'd0);

    // Handshake stalled in the buffer, a second one arrives and is dropped
    handshake_tready = 1'b0;
    send_pkt(C_HDR_HS + 64'h0000_0000_00AA_0000, 8, C_HS, w);
    send_pkt(C_HDR_HS + 64'h0000_0000_00BB_0000, 8, C_NONE, w);
    exp_drop++;
    @(negedge core_clk);
    check("hs_hold", {handshake_tvalid, handshake_tlast, handshake_tdata[61:0]},
          {2'b10, 62'h0000_0000_00AA_0000});
    @(posedge core_clk); #1;
    handshake_tready = 1'b1;
    wait_idle("hs2_drain", 30);
    check_stats("after_drops");

    // Two shutdowns merge into one close event
    close_tready = 1'b0;
    send_pkt(C_HDR_SHUT, 2, C_NONE, w);
    check("close_rise", 64'(close_tvalid), 64'd1);
    close_pend = 1;
    send_pkt(C_HDR_SHUT, 2, C_NONE, w);
    repeat (3) @(posedge core_clk);
    @(negedge core_clk);
    check("close_hold", 64'(close_tvalid), 64'd1);
    @(posedge core_clk); #1;
    close_tready = 1'b1;
    repeat (3) @(posedge core_clk); #1;
    close_tready = 1'b0;
    wait_idle("close_done", 5);
    check("close_cleared", 64'(close_tvalid), 64'd0);

    // ACK stalled by ctrl_tready, then data right behind it
    ctrl_tready = 1'b0;
    s_tdata = C_HDR_ACK; s_tkeep = 8'hFF; s_tlast = 1'b0; s_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge core_clk);
      check("ctrl_stall", {62'd0, s_tready, ctrl_tvalid}, 64'd1);
    end
    @(posedge core_clk); #1;
    ctrl_tready = 1'b1;
    send_pkt(C_HDR_ACK, 3, C_CTRL, w);
    send_pkt(C_HDR_DATA + 64'h0000_0000_0000_5000, 2, C_DATA, w);
    check("no_bubble", 64'(w), 64'd0);
    wait_idle("ctrl_data_drain", 20);
    check_stats("after_ctrl");

    // Reset during beat 4 of a handshake
    for (int i = 0; i < 3; i++) send_beat(C_HDR_HS + 64'(i), 1'b0, w);
    s_tdata = C_HDR_HS + 64'd3; s_tlast = 1'b0; s_tvalid = 1'b1;
    core_rst_n = 1'b0;
    @(posedge core_clk); #1;
    @(negedge core_clk);
    check("reset_mid_pkt", {59'd0, data_tvalid, ctrl_tvalid, handshake_tvalid, close_tvalid, s_tready}, 64'd0);
    @(posedge core_clk); #1;
    s_tvalid = 1'b0; core_rst_n = 1'b1;
    exp_rx = 0; exp_drop = 0;
    send_pkt(C_HDR_HS + 64'h0000_0000_00CC_0000, 8, C_HS, w);
    wait_idle("hs_after_reset", 30);
    check_stats("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
